key_alloc_table: RTL and testbench

- Sequential key table that writes and maintains the flattened key vector and used mask consumed by the key-match index lookup.
- Allocates a slot for a key and returns a 1-based index; index 0 stays reserved as "no match".
- Releases slots by index and reads a key back by index, the reverse of key-to-index lookup.
- Sits beside the decode/dispatch logic that allocates tags and later resolves them through the key-match mux.

---
 rtl/key_alloc_table_if.sv | 35 +++
 rtl/key_alloc_table.sv | 133 +++++++++++++
 tb/tb_key_alloc_table.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/key_alloc_table_if.sv
// Bus bundle for key_alloc_table: allocation handshake, release, read-back
// and the table state exported to the key-match lookup.
interface key_alloc_table_if #(
  parameter int NR = 4,
  parameter int KW = 4,
  parameter int IW = 3
);
  logic               alloc_valid;
  logic               alloc_ready;
  logic [KW-1:0]      alloc_key;
  logic               alloc_done;
  logic [IW-1:0]      alloc_idx;
  logic               alloc_dup;
  logic               free_valid;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      rd_idx;
  logic [KW-1:0]      rd_key;
  logic               rd_hit;
  logic [NR*KW-1:0]   keys;
  logic [NR-1:0]      used;
  logic [IW-1:0]      count;
  logic [7:0]         ovf_cnt;

  modport master (
    output alloc_valid, alloc_key, free_valid, free_idx, rd_idx,
    input  alloc_ready, alloc_done, alloc_idx, alloc_dup, rd_key, rd_hit,
           keys, used, count, ovf_cnt
  );

  modport slave (
    input  alloc_valid, alloc_key, free_valid, free_idx, rd_idx,
    output alloc_ready, alloc_done, alloc_idx, alloc_dup, rd_key, rd_hit,
           keys, used, count, ovf_cnt
  );
endinterface

// File: rtl/key_alloc_table.sv
// Key slot table: allocates 1-based indices for keys, releases by index,
// reads keys back by index. Optional rejected-allocation counter is built
// when KEY_ALLOC_TABLE_OVF_CNT_EN is defined.
module key_alloc_table #(
  parameter int NR = 4,
  parameter int KW = 4,
  parameter int IW = 3
) (
  input logic             clk,
  input logic             rst_n,
  key_alloc_table_if.slave bus
);

  logic [NR-1:0][KW-1:0] key_r;
  logic [NR-1:0]         used_r;
  logic [IW-1:0]         count_r;
  logic                  done_r;
  logic [IW-1:0]         idx_r;
  logic                  dup_r;
  logic [KW-1:0]         rd_key_r;
  logic                  rd_hit_r;

  logic [NR-1:0] free_mask;
  logic          free_any;
  logic          dup_hit;
  logic [IW-1:0] dup_slot;
  logic [IW-1:0] new_slot;
  logic          full;
  logic          accept;
  logic          do_write;
  logic          rd_hit_c;
  logic [KW-1:0] rd_key_c;
  logic [NR-1:0] used_nxt;
  logic [IW-1:0] count_nxt;

  // A slot being validly freed this cycle is invisible to the duplicate
  // search; the free-slot search uses pre-free state so it never picks it.
  always_comb begin
    free_mask = '0;
    dup_hit   = 1'b0;
    dup_slot  = '0;
    new_slot  = '0;
    rd_hit_c  = 1'b0;
    rd_key_c  = '0;
    for (int i = 0; i < NR; i++) begin
      free_mask[i] = bus.free_valid && (bus.free_idx == IW'(i + 1)) && used_r[i];
    end
    for (int i = NR - 1; i >= 0; i--) begin
      if (used_r[i] && !free_mask[i] && (key_r[i] == bus.alloc_key)) begin
        dup_hit  = 1'b1;
        dup_slot = IW'(i);
      end
      if (!used_r[i]) new_slot = IW'(i);
    end
    for (int i = 0; i < NR; i++) begin
      if ((bus.rd_idx == IW'(i + 1)) && used_r[i]) begin
        rd_hit_c = 1'b1;
        rd_key_c = key_r[i];
      end
    end
  end

  // Handshake: a request is accepted on a rising edge where alloc_valid and
  // alloc_ready are both high; alloc_ready never looks at alloc_valid.
  assign free_any = |free_mask;
  assign full     = (count_r == IW'(NR));
  assign accept   = bus.alloc_valid && bus.alloc_ready;
  assign do_write = accept && !dup_hit;

  assign used_nxt = (used_r & ~free_mask) | (do_write ? (NR'(1) << new_slot) : '0);

  always_comb begin
    count_nxt = count_r;
    case ({do_write, free_any})
      2'b10:   count_nxt = count_r + IW'(1);
      2'b01:   count_nxt = count_r - IW'(1);
      default: count_nxt = count_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r    <= '0;
      used_r   <= '0;
      count_r  <= '0;
      done_r   <= 1'b0;
      idx_r    <= '0;
      dup_r    <= 1'b0;
      rd_key_r <= '0;
      rd_hit_r <= 1'b0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (do_write && (new_slot == IW'(i))) key_r[i] <= bus.alloc_key;
      end
      used_r   <= used_nxt;
      count_r  <= count_nxt;
      done_r   <= accept;
      if (accept) begin
        idx_r <= (dup_hit ? dup_slot : new_slot) + IW'(1);
        dup_r <= dup_hit;
      end
      rd_key_r <= rd_key_c;
      rd_hit_r <= rd_hit_c;
    end
  end

`ifdef KEY_ALLOC_TABLE_OVF_CNT_EN
  logic [7:0] ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= '0;
    end else if (bus.alloc_valid && !bus.alloc_ready && (ovf_r != 8'hFF)) begin
      ovf_r <= ovf_r + 8'd1;
    end
  end

  assign bus.ovf_cnt = ovf_r;
`else
  assign bus.ovf_cnt = '0;
`endif

  assign bus.alloc_ready = !full || dup_hit;
  assign bus.alloc_done  = done_r;
  assign bus.alloc_idx   = idx_r;
  assign bus.alloc_dup   = dup_r;
  assign bus.rd_key      = rd_key_r;
  assign bus.rd_hit      = rd_hit_r;
  assign bus.keys        = key_r;
  assign bus.used        = used_r;
  assign bus.count       = count_r;

endmodule

// File: tb/tb_key_alloc_table.sv
// Directed bench for key_alloc_table: allocation responses go through an
// expected queue checked by a monitor; table state and reads are checked inline.
module tb_key_alloc_table;
  localparam int NR = 4;
  localparam int KW = 4;
  localparam int IW = 3;
`ifdef KEY_ALLOC_TABLE_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  key_alloc_table_if #(.NR(NR), .KW(KW), .IW(IW)) bus ();

  key_alloc_table #(.NR(NR), .KW(KW), .IW(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IW:0] exp_q[$];  // {dup, idx}
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // monitor: every alloc_done must match the oldest expected response
  always @(negedge clk) begin
    if (rst_n && bus.alloc_done) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got idx %0d dup %0d, required no done",
                 bus.alloc_idx, bus.alloc_dup);
      end else begin
        check("alloc_resp", {bus.alloc_dup, bus.alloc_idx}, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called at a negedge, return at the next negedge)
  task automatic alloc(input logic [KW-1:0] key, input logic exp_dup, input logic [IW-1:0] exp_idx);
    bus.alloc_valid = 1'b1;
    bus.alloc_key   = key;
    #1;
    check("alloc_ready_hi", bus.alloc_ready, 1);
    exp_q.push_back({exp_dup, exp_idx});
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.free_valid  = 1'b0;
    @(negedge clk);
  endtask

  task automatic free(input logic [IW-1:0] idx);
    bus.free_valid = 1'b1;
    bus.free_idx   = idx;
    @(negedge clk);
    bus.free_valid = 1'b0;
  endtask

  task automatic rd(input logic [IW-1:0] idx, input logic exp_hit, input logic [KW-1:0] exp_key);
    bus.rd_idx = idx;
    @(negedge clk);
    check("rd_hit", bus.rd_hit, exp_hit);
    check("rd_key", bus.rd_key, exp_key);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_key   = '0;
    bus.free_valid  = 1'b0;
    bus.free_idx    = '0;
    bus.rd_idx      = '0;
    repeat (2) @(negedge clk);
    check("rst_count", bus.count, 0);
    check("rst_used", bus.used, 0);
    check("rst_keys", bus.keys, 0);
    check("rst_done", bus.alloc_done, 0);
    check("rst_idx", bus.alloc_idx, 0);
    check("rst_rd_hit", bus.rd_hit, 0);
    check("rst_ovf", bus.ovf_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // three fresh keys on consecutive cycles
    alloc(4'h3, 1'b0, 3'd1);
    alloc(4'h7, 1'b0, 3'd2);
    alloc(4'hA, 1'b0, 3'd3);
    check("count3", bus.count, 3);
    check("used3", bus.used, 4'b0111);
    check("keys3", bus.keys, 16'h0A73);
    idle();

    // duplicate
    alloc(4'h7, 1'b1, 3'd2);
    idle();
    check("count_dup", bus.count, 3);

    // fill, then reject while full
    alloc(4'h5, 1'b0, 3'd4);
    bus.alloc_key = 4'hC;
    #1;
    check("ready_full", bus.alloc_ready, 0);
    @(negedge clk);
    check("count_full", bus.count, 4);
    check("ovf_1", bus.ovf_cnt, OVF_EN ? 1 : 0);

    // free while full: this cycle still rejects, retry lands in slot 2
    bus.free_valid = 1'b1;
    bus.free_idx   = 3'd2;
    #1;
    check("ready_full_free", bus.alloc_ready, 0);
    @(negedge clk);
    bus.free_valid = 1'b0;
    check("count_after_free", bus.count, 3);
    check("used_after_free", bus.used, 4'b1101);
    check("ovf_2", bus.ovf_cnt, OVF_EN ? 2 : 0);
    alloc(4'hC, 1'b0, 3'd2);
    idle();
    check("count_retry", bus.count, 4);
    check("keys_retry", bus.keys, 16'h5AC3);

    // plain free keeps key bits; invalid frees are ignored
    free(3'd4);
    check("count_free4", bus.count, 3);
    check("keys_retained", bus.keys, 16'h5AC3);
    free(3'd0);
    free(3'd5);
    free(3'd4);
    check("count_bad_free", bus.count, 3);
    check("used_bad_free", bus.used, 4'b0111);

    // free slot 1 together with alloc of its key: fresh slot 4, not dup
    bus.free_valid = 1'b1;
    bus.free_idx   = 3'd1;
    alloc(4'h3, 1'b0, 3'd4);
    idle();
    check("count_same_cycle", bus.count, 3);
    check("used_same_cycle", bus.used, 4'b1110);
    check("keys_same_cycle", bus.keys, 16'h3AC3);

    // read-back
    rd(3'd0, 1'b0, 4'h0);
    rd(3'd5, 1'b0, 4'h0);
    rd(3'd1, 1'b0, 4'h0);
    rd(3'd3, 1'b1, 4'hA);
    rd(3'd4, 1'b1, 4'h3);

    // async reset in the middle of an allocation
    bus.alloc_valid = 1'b1;
    bus.alloc_key   = 4'h9;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_done", bus.alloc_done, 0);
    check("arst_idx", bus.alloc_idx, 0);
    check("arst_count", bus.count, 0);
    check("arst_used", bus.used, 0);
    check("arst_keys", bus.keys, 0);
    check("arst_rd_hit", bus.rd_hit, 0);
    check("arst_rd_key", bus.rd_key, 0);
    check("arst_ovf", bus.ovf_cnt, 0);
    bus.alloc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("pending_resp", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
